// File: rtl/sr_input_debouncer.sv
// sr_input_debouncer: synchronizes and debounces two pushbuttons into clean SR latch inputs
// Ports:
//   clk              system clock, all state changes on its rising edge
//   rst              asynchronous active-high reset
//   S_raw, R_raw     raw, bouncing, clk-asynchronous pushbuttons
//   S, R             debounced stable levels driving the latch S/R inputs
//   S_pulse, R_pulse one-cycle pulses on a 0->1 level update; R wins if both rise together
//   conflict         registered S&R, flags the forbidden latch input, one cycle behind S/R
// Build option: define SRDB_SYNC3_EN for 3-flop synchronizer chains (one extra edge of latency).
module sr_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic S_raw,
    input  logic R_raw,
    output logic S,
    output logic R,
    output logic S_pulse,
    output logic R_pulse,
    output logic conflict
);
`ifdef SRDB_SYNC3_EN
    localparam int SYNC_LEN = 3;
`else
    localparam int SYNC_LEN = 2;
`endif
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] raw, lvl, rise;
    logic s_pulse_q, r_pulse_q, conflict_q;
    assign raw = {R_raw, S_raw};
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_LEN-1:0] sync_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic lvl_q, lvl_d, mism, term;
        assign mism = sync_q[SYNC_LEN-1] ^ lvl_q;
        // terminal count reached while still mismatched: adopt the synchronized value
        assign term = mism && (cnt_q == TERM);
        assign cnt_d = (mism && !term) ? cnt_q + 1'b1 : '0;
        assign lvl_d = lvl_q ^ term;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_LEN-2:0], raw[c]};
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
            end
        end
        assign lvl[c]  = lvl_q;
        assign rise[c] = term & ~lvl_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pulse_q  <= 1'b0;
            r_pulse_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_pulse_q  <= rise[0] & ~rise[1];
            r_pulse_q  <= rise[1];
            conflict_q <= lvl[0] & lvl[1];
        end
    end
    assign S        = lvl[0];
    assign R        = lvl[1];
    assign S_pulse  = s_pulse_q;
    assign R_pulse  = r_pulse_q;
    assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_input_debouncer.sv
// tb_sr_input_debouncer: randomized and directed checks of sr_input_debouncer against a sample-history model
module tb_sr_input_debouncer;
    localparam int N = 4;
`ifdef SRDB_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    localparam int LAT = N + SYNC;
    logic clk = 1'b0, rst = 1'b1, s_raw = 1'b0, r_raw = 1'b0;
    logic S, R, S_pulse, R_pulse, conflict;
    logic [4:0] dut_v;
    int checks = 0, errors = 0;
    bit [1:0] hist[$];
    bit [1:0] m_lvl;
    int m_run[2];
    bit m_sp, m_rp, m_conf;
    sr_input_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .S_raw(s_raw), .R_raw(r_raw),
        .S(S), .R(R), .S_pulse(S_pulse), .R_pulse(R_pulse), .conflict(conflict)
    );
    always #5 clk = ~clk;
    assign dut_v = {S, R, S_pulse, R_pulse, conflict};
    function automatic logic [4:0] exp_v();
        return {m_lvl[0], m_lvl[1], m_sp, m_rp, m_conf};
    endfunction
    task automatic model_reset();
        hist.delete();
        repeat (SYNC) hist.push_back(2'b00);
        m_lvl = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
        {m_sp, m_rp, m_conf} = 3'b000;
    endtask
    // hist holds raw samples of the last SYNC edges; the oldest is what the debouncer sees now
    task automatic model_edge();
        bit [1:0] seen, rose;
        seen = hist.pop_front();
        hist.push_back({r_raw, s_raw});
        rose = 2'b00;
        m_conf = m_lvl[0] & m_lvl[1];
        for (int c = 0; c < 2; c++) begin
            if (seen[c] == m_lvl[c]) m_run[c] = 0;
            else begin
                m_run[c]++;
                if (m_run[c] == N) begin
                    m_lvl[c] = seen[c];
                    m_run[c] = 0;
                    rose[c] = seen[c];
                end
            end
        end
        m_rp = rose[1];
        m_sp = rose[0] & ~rose[1];
    endtask
    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask
    task automatic test_reset();
        s_raw = 1'b1;
        r_raw = 1'b1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (dut_v !== 5'b0) begin errors++; $display("FAIL reset_hold cyc%0d got %b exp 00000", i, dut_v); end
        end
        rst = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL reset_model e%0d got %b exp %b", e, dut_v, exp_v()); end
            if (e == LAT - 1) begin
                checks++;
                if ({S, R} !== 2'b00) begin errors++; $display("FAIL reset_early got %b%b exp 00", S, R); end
            end
            if (e == LAT) begin
                checks++;
                if ({S, R, S_pulse, R_pulse} !== 4'b1101) begin errors++; $display("FAIL reset_release got %b exp 1101", {S, R, S_pulse, R_pulse}); end
            end
        end
    endtask
    task automatic test_clean_press();
        s_raw = 1'b0;
        r_raw = 1'b0;
        do_reset();
        s_raw = 1'b1;
        for (int e = 1; e <= LAT + 3; e++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL clean_model e%0d got %b exp %b", e, dut_v, exp_v()); end
            if (e == LAT - 1) begin
                checks++;
                if ({S, S_pulse} !== 2'b00) begin errors++; $display("FAIL clean_early got %b exp 00", {S, S_pulse}); end
            end
            if (e == LAT) begin
                checks++;
                if ({S, S_pulse} !== 2'b11) begin errors++; $display("FAIL clean_rise got %b exp 11", {S, S_pulse}); end
            end
            if (e == LAT + 1) begin
                checks++;
                if ({S, S_pulse} !== 2'b10) begin errors++; $display("FAIL clean_pulse_end got %b exp 10", {S, S_pulse}); end
            end
        end
    endtask
    task automatic test_bounce();
        int rise_e, pulses;
        s_raw = 1'b0;
        r_raw = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            s_raw = ~((i / 2) & 1);
            tick();
            checks++;
            if ({S, S_pulse} !== 2'b00 || dut_v !== exp_v()) begin errors++; $display("FAIL bounce_quiet i%0d got %b exp %b", i, dut_v, exp_v()); end
        end
        s_raw = 1'b1;
        rise_e = -1;
        pulses = 0;
        for (int e = 1; e <= LAT + 6; e++) begin
            tick();
            pulses += S_pulse;
            if (S === 1'b1 && rise_e < 0) rise_e = e;
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL bounce_model e%0d got %b exp %b", e, dut_v, exp_v()); end
        end
        checks++;
        if (rise_e != LAT) begin errors++; $display("FAIL bounce_latency got %0d exp %0d", rise_e, LAT); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", pulses); end
    endtask
    task automatic test_simultaneous();
        s_raw = 1'b0;
        r_raw = 1'b0;
        do_reset();
        s_raw = 1'b1;
        r_raw = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL simul_model e%0d got %b exp %b", e, dut_v, exp_v()); end
            if (e == LAT) begin
                checks++;
                if (dut_v !== 5'b11010) begin errors++; $display("FAIL simul_rise got %b exp 11010", dut_v); end
            end
            if (e == LAT + 1) begin
                checks++;
                if (dut_v !== 5'b11001) begin errors++; $display("FAIL simul_conflict got %b exp 11001", dut_v); end
            end
        end
        s_raw = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL simrel_model e%0d got %b exp %b", e, dut_v, exp_v()); end
            if (e == LAT - 1) begin
                checks++;
                if ({S, conflict} !== 2'b11) begin errors++; $display("FAIL simrel_early got %b exp 11", {S, conflict}); end
            end
            if (e == LAT) begin
                checks++;
                if ({S, S_pulse, conflict} !== 3'b001) begin errors++; $display("FAIL simrel_fall got %b exp 001", {S, S_pulse, conflict}); end
            end
            if (e == LAT + 1) begin
                checks++;
                if ({S, R, conflict} !== 3'b010) begin errors++; $display("FAIL simrel_clear got %b exp 010", {S, R, conflict}); end
            end
        end
    endtask
    task automatic test_reset_mid();
        s_raw = 1'b0;
        r_raw = 1'b0;
        do_reset();
        s_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (dut_v !== 5'b0) begin errors++; $display("FAIL mid_async got %b exp 00000", dut_v); end
        @(posedge clk); #1;
        checks++;
        if (dut_v !== 5'b0) begin errors++; $display("FAIL mid_held got %b exp 00000", dut_v); end
        rst = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL mid_model e%0d got %b exp %b", e, dut_v, exp_v()); end
            if (e == LAT - 1) begin
                checks++;
                if (S !== 1'b0) begin errors++; $display("FAIL mid_early got %b exp 0", S); end
            end
            if (e == LAT) begin
                checks++;
                if ({S, S_pulse} !== 2'b11) begin errors++; $display("FAIL mid_rise got %b exp 11", {S, S_pulse}); end
            end
        end
    endtask
    task automatic test_random();
        logic [1:0] prev_p;
        s_raw = 1'b0;
        r_raw = 1'b0;
        do_reset();
        prev_p = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) s_raw = ~s_raw;
            if ($urandom_range(5) == 0) r_raw = ~r_raw;
            if ($urandom_range(499) == 0) begin
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
                prev_p = 2'b00;
            end
            tick();
            checks++;
            if (dut_v !== exp_v()) begin errors++; $display("FAIL random_model i%0d got %b exp %b", i, dut_v, exp_v()); end
            checks++;
            if ((prev_p & {S_pulse, R_pulse}) !== 2'b00) begin errors++; $display("FAIL random_pulse_width i%0d got %b exp 00", i, prev_p & {S_pulse, R_pulse}); end
            prev_p = {S_pulse, R_pulse};
        end
    endtask
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
